// File: rtl/pci_pkg.sv
// Shared PCI bus definitions used by the initiator and the 4-word target.
package pci_pkg;

    localparam logic [3:0]  PCI_READ       = 4'b0010;
    localparam logic [3:0]  PCI_WRITE      = 4'b0011;
    localparam logic [31:0] DEV_ADDR       = 32'h10;
    localparam int unsigned MAX_WORDS      = 4;
    localparam int unsigned DEVSEL_TIMEOUT = 5;

    localparam int unsigned AW      = 32;
    localparam int unsigned DW      = 32;
    localparam int unsigned CBE_W   = 4;
    localparam int unsigned LEN_W   = 3;
    localparam int unsigned IDX_W   = 2;
    localparam int unsigned TMO_W   = 3;
    localparam int unsigned BE_W    = CBE_W * MAX_WORDS;
    localparam int unsigned BURST_W = DW * MAX_WORDS;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        TURN,
        DATA,
        RELEASE,
        ABORT
    } pci_state_e;

    // Burst request as latched at acceptance; len is stored as the last word index.
    typedef struct packed {
        logic               write;
        logic [AW-1:0]      addr;
        logic [IDX_W-1:0]   last;
        logic [BE_W-1:0]    be;
        logic [BURST_W-1:0] wdata;
    } pci_req_t;

    // Length 0 behaves as 1, anything above MAX_WORDS is clamped.
    function automatic logic [IDX_W-1:0] last_index(input logic [LEN_W-1:0] len);
        if (len == '0) begin
            return '0;
        end
        if (len > LEN_W'(MAX_WORDS)) begin
            return IDX_W'(MAX_WORDS - 1);
        end
        return IDX_W'(len - LEN_W'(1));
    endfunction

endpackage

// File: rtl/pci_initiator.sv
// PCI bus master: runs one 1-4 word read or write burst against the target,
// honouring DEVSEL/TRDY wait states and aborting when no target claims the cycle.
module pci_initiator
    import pci_pkg::*;
(
    input  logic               clk,
    input  logic               RST,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_write,
    input  logic [AW-1:0]      req_addr,
    input  logic [LEN_W-1:0]   req_len,
    input  logic [BE_W-1:0]    req_be,
    input  logic [BURST_W-1:0] req_wdata,
    output logic [BURST_W-1:0] rd_data,
    output logic               done,
    output logic               err,
    output logic               Frame,
    output logic               IRDY,
    output logic [CBE_W-1:0]   CBE,
    inout  wire  [DW-1:0]      AD,
    input  logic               DEVSEL,
    input  logic               TRDY
);

    pci_state_e         state_q, state_d;
    pci_req_t           req_q, req_d;
    logic [IDX_W-1:0]   cnt_q, cnt_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic [BURST_W-1:0] rd_data_q, rd_data_d;
    logic               req_ready_q, req_ready_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic               frame_q, frame_d;
    logic               irdy_q, irdy_d;
    logic               cbe_oe_q, cbe_oe_d;
    logic [CBE_W-1:0]   cbe_q, cbe_d;
    logic               ad_oe_q, ad_oe_d;
    logic [DW-1:0]      ad_out_q, ad_out_d;
    logic               xfer;

    // Next state, counters and captured data.
    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        cnt_d     = cnt_q;
        tmo_d     = tmo_q;
        rd_data_d = rd_data_q;
        xfer      = (state_q == DATA) && !irdy_q && !TRDY && !DEVSEL;

        case (state_q)
            IDLE: begin
                if (req_valid && req_ready_q) begin
                    req_d.write = req_write;
                    req_d.addr  = req_addr;
                    req_d.last  = last_index(req_len);
                    req_d.be    = req_be;
                    req_d.wdata = req_wdata;
                    cnt_d       = '0;
                    tmo_d       = '0;
                    state_d     = ADDR;
                end
            end
            ADDR:    state_d = req_q.write ? DATA : TURN;
            TURN:    state_d = DATA;
            DATA: begin
                if (xfer) begin
                    tmo_d = '0;
                    if (!req_q.write) begin
                        rd_data_d[{cnt_q, 5'd0} +: DW] = AD;
                    end
                    if (cnt_q == req_q.last) begin
                        state_d = RELEASE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else if (DEVSEL) begin
                    tmo_d = tmo_q + 1'b1;
                    if (tmo_d == TMO_W'(DEVSEL_TIMEOUT)) begin
                        state_d = ABORT;
                    end
                end else begin
                    tmo_d = '0;
                end
            end
            RELEASE: state_d = IDLE;
            ABORT:   state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Registered outputs decoded from the state being entered; a wait state re-derives identical values.
        req_ready_d = 1'b0;
        done_d      = 1'b0;
        err_d       = 1'b0;
        frame_d     = 1'b1;
        irdy_d      = 1'b1;
        cbe_oe_d    = 1'b0;
        cbe_d       = '0;
        ad_oe_d     = 1'b0;
        ad_out_d    = '0;

        case (state_d)
            IDLE: req_ready_d = 1'b1;
            ADDR: begin
                frame_d  = 1'b0;
                cbe_oe_d = 1'b1;
                cbe_d    = req_d.write ? PCI_WRITE : PCI_READ;
                ad_oe_d  = 1'b1;
                ad_out_d = req_d.addr;
            end
            TURN: begin
                irdy_d   = 1'b0;
                frame_d  = (req_d.last == '0);
                cbe_oe_d = 1'b1;
                cbe_d    = req_d.be[CBE_W-1:0];
            end
            DATA: begin
                irdy_d   = 1'b0;
                frame_d  = (cnt_d == req_d.last);
                cbe_oe_d = 1'b1;
                cbe_d    = req_d.be[{cnt_d, 2'd0} +: CBE_W];
                if (req_d.write) begin
                    ad_oe_d  = 1'b1;
                    ad_out_d = req_d.wdata[{cnt_d, 5'd0} +: DW];
                end
            end
            RELEASE: done_d = 1'b1;
            ABORT: begin
                done_d = 1'b1;
                err_d  = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            state_q     <= IDLE;
            req_q       <= '0;
            cnt_q       <= '0;
            tmo_q       <= '0;
            rd_data_q   <= '0;
            req_ready_q <= 1'b1;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            frame_q     <= 1'b1;
            irdy_q      <= 1'b1;
            cbe_oe_q    <= 1'b0;
            cbe_q       <= '0;
            ad_oe_q     <= 1'b0;
            ad_out_q    <= '0;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            cnt_q       <= cnt_d;
            tmo_q       <= tmo_d;
            rd_data_q   <= rd_data_d;
            req_ready_q <= req_ready_d;
            done_q      <= done_d;
            err_q       <= err_d;
            frame_q     <= frame_d;
            irdy_q      <= irdy_d;
            cbe_oe_q    <= cbe_oe_d;
            cbe_q       <= cbe_d;
            ad_oe_q     <= ad_oe_d;
            ad_out_q    <= ad_out_d;
        end
    end

    assign req_ready = req_ready_q;
    assign rd_data   = rd_data_q;
    assign done      = done_q;
    assign err       = err_q;
    assign Frame     = frame_q;
    assign IRDY      = irdy_q;
    assign CBE       = cbe_oe_q ? cbe_q : {CBE_W{1'bz}};
    assign AD        = ad_oe_q ? ad_out_q : {DW{1'bz}};

endmodule

// File: tb/tb_pci_initiator.sv
// Bench for pci_initiator: a behavioural 4-word target on the bus plus a
// transaction-level model of memory contents, read data and burst latency.
module tb_pci_initiator;
    import pci_pkg::*;

    logic         clk = 1'b0;
    logic         RST;
    logic         req_valid;
    logic         req_ready;
    logic         req_write;
    logic [31:0]  req_addr;
    logic [2:0]   req_len;
    logic [15:0]  req_be;
    logic [127:0] req_wdata;
    logic [127:0] rd_data;
    logic         done;
    logic         err;
    logic         Frame;
    logic         IRDY;
    logic [3:0]   CBE;
    wire  [31:0]  AD;
    logic         DEVSEL;
    logic         TRDY;

    always #5 clk = ~clk;

    pci_initiator dut (
        .clk(clk), .RST(RST),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_len(req_len), .req_be(req_be), .req_wdata(req_wdata),
        .rd_data(rd_data), .done(done), .err(err),
        .Frame(Frame), .IRDY(IRDY), .CBE(CBE), .AD(AD), .DEVSEL(DEVSEL), .TRDY(TRDY)
    );

    // Behavioural target: claims 0x10, one turnaround cycle on reads, optional wait states before one word.
    logic        tgt_claimed;
    logic        tgt_rd;
    logic        tgt_turn;
    logic [2:0]  tgt_idx;
    int          tgt_wait_left;
    logic [31:0] tgt_mem [4];
    int          cfg_wait_word;
    int          cfg_wait_n;

    assign DEVSEL = ~tgt_claimed;
    assign TRDY   = ~(tgt_claimed && !tgt_turn &&
                      !((int'(tgt_idx) == cfg_wait_word) && (tgt_wait_left != 0)));
    assign AD     = (tgt_claimed && tgt_rd && !tgt_turn) ? tgt_mem[tgt_idx[1:0]] : 32'hzzzzzzzz;

    always @(posedge clk) begin
        if (RST) begin
            tgt_claimed   <= 1'b0;
            tgt_rd        <= 1'b0;
            tgt_turn      <= 1'b0;
            tgt_idx       <= '0;
            tgt_wait_left <= 0;
            for (int i = 0; i < 4; i++) tgt_mem[i] <= '0;
        end else if (!tgt_claimed) begin
            if (!Frame && IRDY && (AD === DEV_ADDR)) begin
                tgt_claimed   <= 1'b1;
                tgt_rd        <= (CBE == PCI_READ);
                tgt_turn      <= (CBE == PCI_READ);
                tgt_idx       <= '0;
                tgt_wait_left <= cfg_wait_n;
            end
        end else begin
            tgt_turn <= 1'b0;
            if (Frame && IRDY) begin
                tgt_claimed <= 1'b0;
            end else if (!IRDY && !TRDY && !DEVSEL) begin
                if (!tgt_rd) tgt_mem[tgt_idx[1:0]] <= (CBE == 4'hF) ? AD : 32'h0;
                tgt_idx <= tgt_idx + 3'd1;
                if (Frame) tgt_claimed <= 1'b0;
            end else if (!tgt_turn && TRDY) begin
                tgt_wait_left <= tgt_wait_left - 1;
            end
        end
    end

    int           vectors;
    int           miscompares;
    logic [31:0]  exp_mem [4];
    logic [127:0] exp_rd;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag, input bit want_ready);
        check({tag, "_frame"}, 128'(Frame), 128'(1'b1));
        check({tag, "_irdy"}, 128'(IRDY), 128'(1'b1));
        check({tag, "_ad_z"}, {96'b0, AD}, {96'b0, 32'hzzzzzzzz});
        check({tag, "_cbe_z"}, {124'b0, CBE}, {124'b0, 4'hz});
        check({tag, "_done"}, 128'(done), 128'(1'b0));
        if (want_ready) check({tag, "_ready"}, 128'(req_ready), 128'(1'b1));
    endtask

    // Runs one burst, checks the bus cycle by cycle against spec-level expectations, then updates the model.
    task automatic run(input bit wr, input logic [31:0] addr, input logic [2:0] len,
                       input logic [15:0] be, input logic [127:0] wd,
                       input int wword, input int wn);
        int  n;
        int  exp_lat;
        int  k;
        bit  seen;
        bit  responds;
        responds = (addr == DEV_ADDR);
        n = (len == 3'd0) ? 1 : ((len > 3'd4) ? 4 : int'(len));
        cfg_wait_word = wword;
        cfg_wait_n    = wn;
        exp_lat = responds ? (n + (wr ? 2 : 3) + ((wword < n) ? wn : 0))
                           : (2 + int'(DEVSEL_TIMEOUT));

        @(negedge clk);
        check("ready_idle", 128'(req_ready), 128'(1'b1));
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_len   = len;
        req_be    = be;
        req_wdata = wd;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        req_write = 1'($urandom);
        req_addr  = $urandom;
        req_len   = 3'($urandom);
        req_be    = 16'($urandom);
        req_wdata = {$urandom, $urandom, $urandom, $urandom};

        check("addr_frame", 128'(Frame), 128'(1'b0));
        check("addr_irdy", 128'(IRDY), 128'(1'b1));
        check("addr_ad", {96'b0, AD}, {96'b0, addr});
        check("addr_cbe", {124'b0, CBE}, {124'b0, (wr ? PCI_WRITE : PCI_READ)});
        check("addr_ready", 128'(req_ready), 128'(1'b0));

        k = 0;
        seen = 1'b0;
        for (int cyc = 2; cyc <= 40 && !seen; cyc++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                check("latency", 128'(cyc), 128'(exp_lat));
                check("err", 128'(err), 128'(!responds));
            end else begin
                check("busy_ready", 128'(req_ready), 128'(1'b0));
                check("data_irdy", 128'(IRDY), 128'(1'b0));
                check("data_frame", 128'(Frame), 128'(k == n - 1));
                check("data_cbe", {124'b0, CBE}, {124'b0, be[4*k +: 4]});
                if (wr)
                    check("data_ad_w", {96'b0, AD}, {96'b0, wd[32*k +: 32]});
                else if (cyc == 2)
                    check("turn_ad_z", {96'b0, AD}, {96'b0, 32'hzzzzzzzz});
                else
                    check("data_ad_r", {96'b0, AD}, {96'b0, exp_mem[k]});
                if (!IRDY && !TRDY && !DEVSEL) k++;
            end
        end
        if (!seen) check("done_timeout", 128'(1'b0), 128'(1'b1));

        if (responds) begin
            for (int i = 0; i < n; i++) begin
                if (wr) exp_mem[i] = (be[4*i +: 4] == 4'hF) ? wd[32*i +: 32] : 32'h0;
                else    exp_rd[32*i +: 32] = exp_mem[i];
            end
        end
        check("rd_data", rd_data, exp_rd);
        @(negedge clk);
        for (int i = 0; i < 4; i++) check("tgt_mem", {96'b0, tgt_mem[i]}, {96'b0, exp_mem[i]});
        check_idle("after", 1'b1);
    endtask

    initial begin
        vectors       = 0;
        miscompares   = 0;
        cfg_wait_word = 0;
        cfg_wait_n    = 0;
        exp_rd        = '0;
        for (int i = 0; i < 4; i++) exp_mem[i] = '0;
        RST       = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_len   = '0;
        req_be    = '0;
        req_wdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_idle("reset", 1'b1);
        check("reset_err", 128'(err), 128'(1'b0));
        check("reset_rd", rd_data, 128'(0));
        RST = 1'b0;

        run(1'b1, 32'h10, 3'd4, 16'hF0F0, {32'h1004, 32'h1003, 32'h1002, 32'h1001}, 4, 0);
        run(1'b0, 32'h10, 3'd4, 16'h0000, '0, 4, 0);
        run(1'b0, 32'h10, 3'd4, 16'hFFFF, '0, 1, 2);
        run(1'b1, 32'h20, 3'd4, 16'hFFFF, {4{32'hDEAD_BEEF}}, 4, 0);
        run(1'b1, 32'h10, 3'd1, 16'h000F, {96'b0, 32'hABCD}, 4, 0);
        run(1'b1, 32'h10, 3'd0, 16'h000F, {96'b0, 32'h5555_0000}, 4, 0);
        run(1'b0, 32'h10, 3'd7, 16'h0F0F, '0, 3, 1);
        run(1'b0, 32'h10, 3'd1, 16'hFFFF, '0, 0, 3);

        // Reset in the middle of a 4-word write: bus idles at once and no done follows.
        cfg_wait_n = 0;
        @(negedge clk);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 32'h10;
        req_len   = 3'd4;
        req_be    = 16'hFFFF;
        req_wdata = {4{32'h7777_7777}};
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (2) @(negedge clk);
        RST = 1'b1;
        @(posedge clk);
        @(negedge clk);
        RST = 1'b0;
        for (int i = 0; i < 4; i++) exp_mem[i] = '0;
        exp_rd = '0;
        check_idle("midrst", 1'b1);
        check("midrst_rd", rd_data, 128'(0));
        repeat (3) begin
            @(negedge clk);
            check("midrst_nodone", 128'(done), 128'(1'b0));
        end
        run(1'b0, 32'h10, 3'd4, 16'hFFFF, '0, 4, 0);

        for (int t = 0; t < 24; t++) begin
            bit           wr;
            logic [31:0]  addr;
            logic [15:0]  be;
            for (int w = 0; w < 4; w++) be[4*w +: 4] = ($urandom_range(0, 1) != 0) ? 4'hF : 4'h0;
            wr   = ($urandom_range(0, 1) != 0);
            addr = (wr && ($urandom_range(0, 5) == 0)) ? 32'h20 : 32'h10;
            run(wr, addr, 3'($urandom_range(0, 7)), be,
                {$urandom, $urandom, $urandom, $urandom},
                $urandom_range(0, 3), $urandom_range(0, 3));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
